// File: rtl/rate_coder_scheduler_pkg.sv
// snn_enc_pkg: shared FSM states, LFSR seed/taps and step function for the rate coder.
package snn_enc_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, PRESENT, DONE} state_t;
    localparam logic [15:0] LFSR_SEED = 16'd5893;
    // Feedback taps at bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/rate_coder_scheduler_if.sv
// rate_coder_scheduler_if: pixel config, window control and spike-vector handshake bundle.
interface rate_coder_scheduler_if #(parameter int NPIX = 16, parameter int TSTEPS = 32);
    localparam int AW = $clog2(NPIX);
    localparam int TW = TSTEPS > 1 ? $clog2(TSTEPS) : 1;
    logic cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [15:0] cfg_data;
    logic start;
    logic busy;
    logic spk_valid;
    logic spk_ready;
    logic [NPIX-1:0] spk_vec;
    logic [TW-1:0] spk_t;
    logic spk_last;
    logic done;
    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, spk_ready,
        output busy, spk_valid, spk_vec, spk_t, spk_last, done
    );
    modport master (
        output cfg_we, cfg_addr, cfg_data, start, spk_ready,
        input  busy, spk_valid, spk_vec, spk_t, spk_last, done
    );
endinterface

// File: rtl/rate_coder_scheduler_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with synchronous seed load and step enable.
module lfsr16
    import snn_enc_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= SEED;
        else if (load)
            q <= SEED;
        else if (en)
            q <= lfsr_next(q);
    end
endmodule

// File: rtl/rate_coder_scheduler.sv
// rate_coder_scheduler: one shared LFSR comparator rate-codes NPIX pixels into TSTEPS spike vectors.
module rate_coder_scheduler
    import snn_enc_pkg::*;
#(
    parameter int          NPIX   = 16,
    parameter int          TSTEPS = 32,
    parameter bit          CMP    = 1'b1,
    parameter logic [15:0] SEED   = LFSR_SEED
) (
    input  logic clk,
    input  logic rst,
    rate_coder_scheduler_if.slave bus
);
    localparam int AW = $clog2(NPIX);
    localparam int TW = TSTEPS > 1 ? $clog2(TSTEPS) : 1;

    state_t state, nxt;
    logic [15:0] pix [NPIX];
    logic [AW-1:0] idx;
    logic [TW-1:0] t;
    logic [NPIX-1:0] vec;
    logic [15:0] lfsr;
    logic busy_q, done_q;

    wire idle     = state == IDLE;
    wire scan     = state == SCAN;
    wire present  = state == PRESENT;
    wire go       = idle && bus.start;
    wire hs       = present && bus.spk_ready;
    wire last_idx = idx == AW'(NPIX - 1);
    wire last_t   = t == TW'(TSTEPS - 1);
    wire addr_ok  = {1'b0, bus.cfg_addr} < (AW + 1)'(NPIX);

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (go),
        .en   (scan),
        .q    (lfsr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (go)
            nxt = SCAN;
        else if (scan && last_idx)
            nxt = PRESENT;
        else if (hs)
            nxt = last_t ? DONE : SCAN;
        else if (state == DONE)
            nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPIX; i++)
                pix[i] <= '0;
            idx    <= '0;
            t      <= '0;
            vec    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (idle && bus.cfg_we && addr_ok)
                pix[bus.cfg_addr] <= bus.cfg_data;
            if (go) begin
                idx    <= '0;
                t      <= '0;
                busy_q <= 1'b1;
            end
            // Bits are rewritten in place; the vector is only visible once PRESENT raises valid.
            if (scan) begin
                vec[idx] <= (pix[idx] < lfsr) ^ CMP;
                idx      <= last_idx ? '0 : idx + 1'b1;
            end
            if (hs && !last_t)
                t <= t + 1'b1;
            done_q <= state == DONE;
            if (state == DONE)
                busy_q <= 1'b0;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.spk_valid = present;
    assign bus.spk_vec   = vec;
    assign bus.spk_t     = t;
    assign bus.spk_last  = present && last_t;
    assign bus.done      = done_q;
endmodule
